// File: rtl/flappy_game_core.sv
// flappy_game_core: bird physics, flap debounce, game FSM and BCD score keeping.
// Sits between the board inputs and the VGA / seven-segment display paths.
//   clk_i        game clock
//   clr_i        asynchronous active-high reset
//   tick_i       one-cycle frame strobe; physics and FSM advance only on it
//   flap_i       raw asynchronous pushbutton
//   collide_i    pipe collision level, sampled on tick
//   pipe_pass_i  one-cycle pulse when the bird clears a pipe
//   bird_y_o     bird top edge, 0 = top of screen
//   bird_vel_o   signed velocity, negative = up
//   state_o      00 idle, 01 play, 10 dead
//   game_over_o  high while dead
//   score_o      BCD score, digit 0 = LSD
//   hi_score_o   BCD best score since reset
module flappy_game_core #(
   parameter int unsigned Y_W          = 10,
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned BIRD_H       = 16,
   parameter int unsigned Y_START      = 240,
   parameter int unsigned GRAVITY      = 1,
   parameter int unsigned FLAP_IMP     = 8,
   parameter int unsigned V_MAX        = 8,
   parameter int unsigned V_W          = 6,
   parameter int unsigned DB_CYCLES    = 1000000,
   parameter int unsigned SCORE_DIGITS = 4
) (
   input  logic                        clk_i,
   input  logic                        clr_i,
   input  logic                        tick_i,
   input  logic                        flap_i,
   input  logic                        collide_i,
   input  logic                        pipe_pass_i,
   output logic [Y_W-1:0]              bird_y_o,
   output logic signed [V_W-1:0]       bird_vel_o,
   output logic [1:0]                  state_o,
   output logic                        game_over_o,
   output logic [4*SCORE_DIGITS-1:0]   score_o,
   output logic [4*SCORE_DIGITS-1:0]   hi_score_o
);

   localparam logic [1:0] StIdle = 2'b00;
   localparam logic [1:0] StPlay = 2'b01;
   localparam logic [1:0] StDead = 2'b10;

   localparam int unsigned SW    = Y_W + 2;
   localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
   localparam int unsigned SC_W  = 4 * SCORE_DIGITS;

   localparam logic [CNT_W-1:0]      DB_MAX    = CNT_W'(DB_CYCLES - 1);
   localparam logic [Y_W-1:0]        Y_START_V = Y_W'(Y_START);
   localparam logic [Y_W-1:0]        Y_FLAP_V  = Y_W'(Y_START - FLAP_IMP);
   localparam logic [Y_W-1:0]        Y_FLOOR_V = Y_W'(SCREEN_H - BIRD_H);
   localparam logic signed [SW-1:0]  Y_FLOOR_S = SW'(SCREEN_H - BIRD_H);
   localparam logic signed [V_W:0]   GRAV_E    = (V_W + 1)'(GRAVITY);
   localparam logic signed [V_W:0]   VMAX_E    = (V_W + 1)'(V_MAX);
   localparam logic signed [V_W-1:0] FLAP_V    = V_W'(0) - V_W'(FLAP_IMP);

   // ---------------- flap input path ----------------
   logic             flap_s1_q, flap_s2_q;
   logic             flap_db_q, flap_db_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             flap_pend_q, flap_pend_d;
   logic             db_rise, flap_req;

   // Debounced level only follows the synced level after DB_CYCLES
   // consecutive samples that differ from it.
   always_comb begin
      flap_db_d = flap_db_q;
      db_cnt_d  = '0;
      db_rise   = 1'b0;
      if (flap_s2_q != flap_db_q) begin
         if (db_cnt_q == DB_MAX) begin
            flap_db_d = flap_s2_q;
            db_rise   = flap_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign flap_req    = flap_pend_q | db_rise;
   // Every tick consumes or discards a pending request.
   assign flap_pend_d = tick_i ? 1'b0 : flap_req;

   // ---------------- game state ----------------
   logic [1:0]              state_q, state_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic signed [V_W-1:0]   vel_q, vel_d;
   logic [SC_W-1:0]         score_q, score_d, score_inc;
   logic [SC_W-1:0]         hi_q, hi_d;

   // Saturating BCD increment.
   logic carry, all_nines;
   always_comb begin
      score_inc = score_q;
      carry     = 1'b1;
      all_nines = 1'b1;
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
         if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      if (all_nines) score_inc = score_q;
   end

   // Physics: v' then y' in Y_W+2 signed bits so ceiling/floor overshoot is visible.
   logic signed [V_W:0]    vel_g;
   logic signed [V_W-1:0]  v_new;
   logic signed [SW-1:0]   y_sum;
   logic                   floor_hit;

   always_comb begin
      vel_g = {vel_q[V_W-1], vel_q} + GRAV_E;
      if (flap_req)           v_new = FLAP_V;
      else if (vel_g > VMAX_E) v_new = VMAX_E[V_W-1:0];
      else                    v_new = vel_g[V_W-1:0];
      y_sum     = $signed({2'b00, y_q}) + {{(SW-V_W){v_new[V_W-1]}}, v_new};
      floor_hit = !y_sum[SW-1] && (y_sum >= Y_FLOOR_S);
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      score_d = score_q;
      hi_d    = hi_q;
      // Score runs between ticks too; a pass on the dying tick still counts.
      if (pipe_pass_i && state_q == StPlay) score_d = score_inc;
      if (tick_i) begin
         case (state_q)
            StIdle: begin
               if (flap_req) begin
                  state_d = StPlay;
                  vel_d   = FLAP_V;
                  y_d     = Y_FLAP_V;
               end else begin
                  vel_d = '0;
                  y_d   = Y_START_V;
               end
            end
            StPlay: begin
               vel_d = v_new;
               if (y_sum[SW-1])   y_d = '0;
               else if (floor_hit) y_d = Y_FLOOR_V;
               else               y_d = y_sum[Y_W-1:0];
               if (floor_hit || collide_i) begin
                  state_d = StDead;
                  vel_d   = '0;
                  // BCD order matches numeric order, so a plain compare works.
                  if (score_d > hi_q) hi_d = score_d;
               end
            end
            StDead: begin
               vel_d = '0;
               if (flap_req) begin
                  state_d = StIdle;
                  y_d     = Y_START_V;
                  score_d = '0;
               end
            end
            default: begin
               state_d = StIdle;
               y_d     = Y_START_V;
               vel_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         flap_s1_q   <= 1'b0;
         flap_s2_q   <= 1'b0;
         flap_db_q   <= 1'b0;
         db_cnt_q    <= '0;
         flap_pend_q <= 1'b0;
         state_q     <= StIdle;
         y_q         <= Y_START_V;
         vel_q       <= '0;
         score_q     <= '0;
         hi_q        <= '0;
      end else begin
         flap_s1_q   <= flap_i;
         flap_s2_q   <= flap_s1_q;
         flap_db_q   <= flap_db_d;
         db_cnt_q    <= db_cnt_d;
         flap_pend_q <= flap_pend_d;
         state_q     <= state_d;
         y_q         <= y_d;
         vel_q       <= vel_d;
         score_q     <= score_d;
         hi_q        <= hi_d;
      end
   end

   assign bird_y_o    = y_q;
   assign bird_vel_o  = vel_q;
   assign state_o     = state_q;
   assign game_over_o = (state_q == StDead);
   assign score_o     = score_q;
   assign hi_score_o  = hi_q;

endmodule

// File: tb/tb_flappy_game_core.sv
// Self-checking bench for flappy_game_core with a short debounce window.
module tb_flappy_game_core;

   logic        clk_i = 1'b0;
   logic        clr_i = 1'b1;
   logic        tick_i = 1'b0;
   logic        flap_i = 1'b0;
   logic        collide_i = 1'b0;
   logic        pipe_pass_i = 1'b0;
   logic [9:0]  bird_y_o;
   logic signed [5:0] bird_vel_o;
   logic [1:0]  state_o;
   logic        game_over_o;
   logic [15:0] score_o;
   logic [15:0] hi_score_o;

   int errors = 0;
   int checks = 0;

   flappy_game_core #(
      .DB_CYCLES(4)
   ) dut (
      .clk_i      (clk_i),
      .clr_i      (clr_i),
      .tick_i     (tick_i),
      .flap_i     (flap_i),
      .collide_i  (collide_i),
      .pipe_pass_i(pipe_pass_i),
      .bird_y_o   (bird_y_o),
      .bird_vel_o (bird_vel_o),
      .state_o    (state_o),
      .game_over_o(game_over_o),
      .score_o    (score_o),
      .hi_score_o (hi_score_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int y;
      int vel;
   } phys_t;
   phys_t tbl[17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_tick();
      tick_i = 1'b1;
      cyc();
      tick_i = 1'b0;
   endtask

   // Hold long enough to clear sync + debounce, then release and let it settle.
   task automatic press();
      flap_i = 1'b1;
      repeat (6) cyc();
      flap_i = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         pipe_pass_i = 1'b1;
         cyc();
         pipe_pass_i = 1'b0;
         cyc();
      end
   endtask

   task automatic chk_vel(input string name, input int exp);
      chk(name, int'(bird_vel_o), exp);
   endtask

   initial begin
      tbl[0]  = '{225, -7}; tbl[1]  = '{219, -6}; tbl[2]  = '{214, -5};
      tbl[3]  = '{210, -4}; tbl[4]  = '{207, -3}; tbl[5]  = '{205, -2};
      tbl[6]  = '{204, -1}; tbl[7]  = '{204,  0}; tbl[8]  = '{205,  1};
      tbl[9]  = '{207,  2}; tbl[10] = '{210,  3}; tbl[11] = '{214,  4};
      tbl[12] = '{219,  5}; tbl[13] = '{225,  6}; tbl[14] = '{232,  7};
      tbl[15] = '{240,  8}; tbl[16] = '{248,  8};

      repeat (2) cyc();
      clr_i = 1'b0;
      cyc();
      chk("reset_y", int'(bird_y_o), 240);
      chk_vel("reset_vel", 0);
      chk("reset_state", int'(state_o), 0);
      chk("reset_game_over", int'(game_over_o), 0);
      chk("reset_score", int'(score_o), 0);
      chk("reset_hi", int'(hi_score_o), 0);

      // Short press must not pass the debouncer.
      flap_i = 1'b1;
      repeat (3) cyc();
      flap_i = 1'b0;
      repeat (8) cyc();
      do_tick();
      chk("short_press_state", int'(state_o), 0);
      chk("short_press_y", int'(bird_y_o), 240);
      pulses(1);
      chk("idle_pass_ignored", int'(score_o), 0);

      press();
      do_tick();
      chk("start_state", int'(state_o), 1);
      chk_vel("start_vel", -8);
      chk("start_y", int'(bird_y_o), 232);

      // Free fall up to terminal velocity.
      for (int i = 0; i < 17; i++) begin
         do_tick();
         chk($sformatf("fall_y[%0d]", i), int'(bird_y_o), tbl[i].y);
         chk_vel($sformatf("fall_vel[%0d]", i), tbl[i].vel);
      end
      for (int k = 1; k <= 26; k++) begin
         do_tick();
         chk($sformatf("term_y[%0d]", k), int'(bird_y_o), 248 + 8 * k);
         chk("term_state", int'(state_o), 1);
      end
      // 456 + 8 reaches the floor exactly.
      do_tick();
      chk("floor_y", int'(bird_y_o), 464);
      chk("floor_state", int'(state_o), 2);
      chk("floor_game_over", int'(game_over_o), 1);
      repeat (3) cyc();
      chk("dead_hold_y", int'(bird_y_o), 464);
      press();
      do_tick();
      chk("restart_state", int'(state_o), 0);
      chk("restart_y", int'(bird_y_o), 240);
      chk("restart_score", int'(score_o), 0);

      // Game with 5 passes sets hi to 5.
      press();
      do_tick();
      pulses(5);
      chk("score5", int'(score_o), 16'h0005);
      collide_i = 1'b1;
      do_tick();
      collide_i = 1'b0;
      chk("collide_state", int'(state_o), 2);
      chk("hi5", int'(hi_score_o), 16'h0005);
      pulses(1);
      chk("dead_pass_ignored", int'(score_o), 16'h0005);
      press();
      do_tick();
      chk("score_cleared", int'(score_o), 0);
      chk("hi_kept", int'(hi_score_o), 16'h0005);

      // 12 passes, death raises hi to 12.
      press();
      do_tick();
      pulses(12);
      chk("score12", int'(score_o), 16'h0012);
      collide_i = 1'b1;
      do_tick();
      collide_i = 1'b0;
      chk("hi12", int'(hi_score_o), 16'h0012);

      // Saturation at 9999.
      press();
      do_tick();
      press();
      do_tick();
      pipe_pass_i = 1'b1;
      repeat (9999) cyc();
      pipe_pass_i = 1'b0;
      chk("score9999", int'(score_o), 16'h9999);
      pulses(1);
      chk("score_sat", int'(score_o), 16'h9999);
      collide_i = 1'b1;
      do_tick();
      collide_i = 1'b0;
      chk("hi9999", int'(hi_score_o), 16'h9999);

      // Ceiling clamp, then collide + pass on the same tick.
      press();
      do_tick();
      press();
      do_tick();
      do_tick();
      chk("ceil_pre_y", int'(bird_y_o), 225);
      for (int i = 0; i < 28; i++) begin
         press();
         do_tick();
      end
      chk("ceil_y1", int'(bird_y_o), 1);
      chk_vel("ceil_vel1", -8);
      press();
      do_tick();
      chk("ceil_clamp_y", int'(bird_y_o), 0);
      chk("ceil_state", int'(state_o), 1);
      collide_i   = 1'b1;
      pipe_pass_i = 1'b1;
      do_tick();
      collide_i   = 1'b0;
      pipe_pass_i = 1'b0;
      chk("dying_pass_state", int'(state_o), 2);
      chk("dying_pass_score", int'(score_o), 16'h0001);
      chk("hi_not_lowered", int'(hi_score_o), 16'h9999);

      // Asynchronous clear mid-play.
      press();
      do_tick();
      press();
      do_tick();
      pulses(7);
      chk("pre_clr_score", int'(score_o), 16'h0007);
      #2;
      clr_i = 1'b1;
      #1;
      chk("clr_y", int'(bird_y_o), 240);
      chk("clr_state", int'(state_o), 0);
      chk("clr_score", int'(score_o), 0);
      chk("clr_hi", int'(hi_score_o), 0);
      chk_vel("clr_vel", 0);
      chk("clr_game_over", int'(game_over_o), 0);
      cyc();
      clr_i = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
